// File: rtl/issue_scoreboard_ctrl_pkg.sv
// Shared types and opcode classification helpers for the in-order issue controller.
package issue_scoreboard_ctrl_pkg;

  localparam int cRegAddrW = 5;
  localparam int cNumRegs  = 32;

  // RV32I major opcodes; eNOOP marks an empty/bubble slot that reads and writes nothing.
  typedef enum logic [6:0] {
    eNOOP    = 7'b0000000,
    eLoad    = 7'b0000011,
    eFence   = 7'b0001111,
    eImmedi  = 7'b0010011,
    eAuIpc   = 7'b0010111,
    eStore   = 7'b0100011,
    eRtype   = 7'b0110011,
    eLui     = 7'b0110111,
    eBranch  = 7'b1100011,
    eJalr    = 7'b1100111,
    eJal     = 7'b1101111,
    eCntrlSt = 7'b1110011
  } tOpcodeEnum;

  typedef enum logic [1:0] {eRun, eBrWait, eDrain} tIssueStateEnum;

  function automatic logic fReadsRs1(input tOpcodeEnum op);
    case (op)
      eRtype, eBranch, eStore, eLoad, eImmedi, eJalr: fReadsRs1 = 1'b1;
      default:                                        fReadsRs1 = 1'b0;
    endcase
  endfunction

  function automatic logic fReadsRs2(input tOpcodeEnum op);
    case (op)
      eRtype, eBranch, eStore: fReadsRs2 = 1'b1;
      default:                 fReadsRs2 = 1'b0;
    endcase
  endfunction

  function automatic logic fWritesRd(input tOpcodeEnum op);
    case (op)
      eLoad, eRtype, eImmedi, eJalr, eJal, eLui, eAuIpc: fWritesRd = 1'b1;
      default:                                          fWritesRd = 1'b0;
    endcase
  endfunction

  function automatic logic fIsCtrlFlow(input tOpcodeEnum op);
    case (op)
      eBranch, eJal, eJalr: fIsCtrlFlow = 1'b1;
      default:              fIsCtrlFlow = 1'b0;
    endcase
  endfunction

  function automatic logic fIsDrain(input tOpcodeEnum op);
    case (op)
      eFence, eCntrlSt: fIsDrain = 1'b1;
      default:          fIsDrain = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Pending-destination vector plus in-flight counter; x0 can never become pending.
module issue_scoreboard
  import issue_scoreboard_ctrl_pkg::*;
#(
  parameter int pCntW = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [cRegAddrW-1:0] set_rd,
  input  logic                 clr_en,
  input  logic [cRegAddrW-1:0] clr_rd,
  input  logic [cRegAddrW-1:0] rd_addr_a,
  input  logic [cRegAddrW-1:0] rd_addr_b,
  input  logic [cRegAddrW-1:0] rd_addr_c,
  output logic                 pend_a,
  output logic                 pend_b,
  output logic                 pend_c,
  output logic                 clr_err,
  output logic [pCntW-1:0]     count
);

  logic [cNumRegs-1:0] pending_q, pending_d;
  logic [pCntW-1:0]    count_q, count_d;
  logic                set_hit;
  logic                clr_hit;

  assign set_hit = set_en && (set_rd != '0);
  assign clr_hit = clr_en && pending_q[clr_rd];
  assign clr_err = clr_en && !pending_q[clr_rd];

  assign pend_a = pending_q[rd_addr_a];
  assign pend_b = pending_q[rd_addr_b];
  assign pend_c = pending_q[rd_addr_c];
  assign count  = count_q;

  // Apply the issue-side set and writeback-side clear; a simultaneous pair leaves the count unchanged.
  always_comb begin
    pending_d = pending_q;
    count_d   = count_q;
    if (set_hit) pending_d[set_rd] = 1'b1;
    if (clr_hit) pending_d[clr_rd] = 1'b0;
    if (set_hit && !clr_hit)      count_d = count_q + pCntW'(1);
    else if (!set_hit && clr_hit) count_d = count_q - pCntW'(1);
  end

  // Scoreboard state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: rtl/issue_scoreboard_ctrl.sv
// In-order issue controller: hazard stall, branch hold, fence/system drain and flush pulse.
module issue_scoreboard_ctrl
  import issue_scoreboard_ctrl_pkg::*;
#(
  parameter int pMaxInflight = 4,
  parameter int pCntW        = $clog2(pMaxInflight + 1)
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iDecValid,
  input  logic [6:0]       iDecOpcode,
  input  logic [4:0]       iDecRs1,
  input  logic [4:0]       iDecRs2,
  input  logic [4:0]       iDecRd,
  output logic             oDecReady,
  output logic             oIssueValid,
  input  logic             iIssueReady,
  input  logic             iWbValid,
  input  logic [4:0]       iWbRd,
  input  logic             iBrResolve,
  input  logic             iBrTaken,
  output logic             oFlush,
  output logic [pCntW-1:0] oInflightCnt,
  output logic             oWbErr
);

  tOpcodeEnum     dec_op;
  tIssueStateEnum state_q, state_d;
  logic           flush_q, flush_d;
  logic           wb_err_q, wb_err_d;
  logic           rs1_pend, rs2_pend, rd_pend;
  logic           clr_err;
  logic [pCntW-1:0] count;
  logic           writes_rd, src_hazard, stall, issue;
  logic           count_full, count_zero;

  assign dec_op = tOpcodeEnum'(iDecOpcode);

  issue_scoreboard #(
    .pCntW(pCntW)
  ) u_scoreboard (
    .clk      (iClk),
    .rst      (iRst),
    .set_en   (issue && writes_rd),
    .set_rd   (iDecRd),
    .clr_en   (iWbValid),
    .clr_rd   (iWbRd),
    .rd_addr_a(iDecRs1),
    .rd_addr_b(iDecRs2),
    .rd_addr_c(iDecRd),
    .pend_a   (rs1_pend),
    .pend_b   (rs2_pend),
    .pend_c   (rd_pend),
    .clr_err  (clr_err),
    .count    (count)
  );

  // Hazard and issue handshake; scoreboard reads are registered so a writeback frees its dependent one cycle later.
  always_comb begin
    writes_rd   = fWritesRd(dec_op) && (iDecRd != '0);
    src_hazard  = (fReadsRs1(dec_op) && rs1_pend) || (fReadsRs2(dec_op) && rs2_pend);
    count_full  = (count == pCntW'(pMaxInflight));
    count_zero  = (count == '0);
    stall       = (state_q != eRun) || src_hazard
                || (writes_rd && rd_pend)
                || (writes_rd && count_full)
                || (fIsDrain(dec_op) && !count_zero);
    oIssueValid = iDecValid && !stall;
    oDecReady   = oIssueValid && iIssueReady;
    issue       = oDecReady;
  end

  // Next-state logic for the issue FSM, the flush pulse and the sticky writeback error.
  always_comb begin
    state_d  = state_q;
    flush_d  = 1'b0;
    wb_err_d = wb_err_q || clr_err;
    case (state_q)
      eRun: begin
        if (issue && fIsCtrlFlow(dec_op))                     state_d = eBrWait;
        else if (iDecValid && fIsDrain(dec_op) && !count_zero) state_d = eDrain;
      end
      eBrWait: begin
        if (iBrResolve) begin
          state_d = eRun;
          flush_d = iBrTaken;
        end
      end
      eDrain: begin
        if (count_zero) state_d = eRun;
      end
      default: state_d = eRun;
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= eRun;
      flush_q  <= 1'b0;
      wb_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      wb_err_q <= wb_err_d;
    end
  end

  assign oFlush       = flush_q;
  assign oWbErr       = wb_err_q;
  assign oInflightCnt = count;

endmodule

// File: tb/tb_issue_scoreboard_ctrl.sv
// Scoreboard bench: stimulus queues expected issues/status per cycle, a negedge monitor compares.
module tb_issue_scoreboard_ctrl;
  import issue_scoreboard_ctrl_pkg::*;

  localparam int K_CNT = 0, K_FLUSH = 1, K_ERR = 2, K_IV = 3, K_DR = 4;

  typedef struct {
    int         cyc;
    logic [6:0] op;
    logic [4:0] rd;
  } issue_t;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } status_t;

  logic       clk = 1'b0;
  logic       iRst = 1'b1;
  logic       iDecValid = 1'b0;
  logic [6:0] iDecOpcode = '0;
  logic [4:0] iDecRs1 = '0, iDecRs2 = '0, iDecRd = '0;
  logic       iIssueReady = 1'b0;
  logic       iWbValid = 1'b0;
  logic [4:0] iWbRd = '0;
  logic       iBrResolve = 1'b0, iBrTaken = 1'b0;
  logic       oDecReady, oIssueValid, oFlush, oWbErr;
  logic [2:0] oInflightCnt;

  int      cyc = 0;
  int      checks = 0;
  int      errors = 0;
  bit      done = 1'b0;
  bit      final_done = 1'b0;
  issue_t  issue_q[$];
  status_t status_q[$];
  issue_t  exp_issue;
  status_t exp_stat;

  issue_scoreboard_ctrl #(.pMaxInflight(4)) dut (
    .iClk        (clk),
    .iRst        (iRst),
    .iDecValid   (iDecValid),
    .iDecOpcode  (iDecOpcode),
    .iDecRs1     (iDecRs1),
    .iDecRs2     (iDecRs2),
    .iDecRd      (iDecRd),
    .oDecReady   (oDecReady),
    .oIssueValid (oIssueValid),
    .iIssueReady (iIssueReady),
    .iWbValid    (iWbValid),
    .iWbRd       (iWbRd),
    .iBrResolve  (iBrResolve),
    .iBrTaken    (iBrTaken),
    .oFlush      (oFlush),
    .oInflightCnt(oInflightCnt),
    .oWbErr      (oWbErr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare each issue handshake and every status entry due this cycle.
  always @(negedge clk) begin
    if (!iRst) begin
      if (oDecReady) begin
        if (issue_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_issue at cycle %0d: got op=%h rd=%0d, required no issue",
                   cyc, iDecOpcode, iDecRd);
        end else begin
          exp_issue = issue_q.pop_front();
          checkOutput("issue_cycle", cyc, exp_issue.cyc);
          checkOutput("issue_op", int'(iDecOpcode), int'(exp_issue.op));
          checkOutput("issue_rd", int'(iDecRd), int'(exp_issue.rd));
        end
      end
      while (status_q.size() != 0 && status_q[0].cyc <= cyc) begin
        exp_stat = status_q.pop_front();
        case (exp_stat.kind)
          K_CNT:   checkOutput("inflight_cnt", int'(oInflightCnt), exp_stat.val);
          K_FLUSH: checkOutput("flush", int'(oFlush), exp_stat.val);
          K_ERR:   checkOutput("wb_err", int'(oWbErr), exp_stat.val);
          K_IV:    checkOutput("issue_valid", int'(oIssueValid), exp_stat.val);
          default: checkOutput("dec_ready", int'(oDecReady), exp_stat.val);
        endcase
      end
    end
    if (done && !final_done) begin
      final_done = 1'b1;
      checkOutput("pending_issues_left", issue_q.size(), 0);
      checkOutput("pending_status_left", status_q.size(), 0);
    end
  end

  task automatic expectIssue(input logic [6:0] op, input logic [4:0] rd);
    issue_t e;
    e.cyc = cyc;
    e.op  = op;
    e.rd  = rd;
    issue_q.push_back(e);
  endtask

  task automatic expectStatus(input int kind, input int val);
    status_t s;
    s.cyc  = cyc;
    s.kind = kind;
    s.val  = val;
    status_q.push_back(s);
  endtask

  task automatic expectResetState();
    expectStatus(K_CNT, 0);
    expectStatus(K_FLUSH, 0);
    expectStatus(K_ERR, 0);
    expectStatus(K_IV, 0);
    expectStatus(K_DR, 0);
  endtask

  // Drive one cycle of inputs, then advance to just after the next rising edge.
  task automatic applyStimulus(input logic valid, input logic [6:0] op,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic ready,
                               input logic wb_v = 1'b0, input logic [4:0] wb_rd = 5'd0,
                               input logic br_res = 1'b0, input logic br_tk = 1'b0);
    iDecValid   = valid;
    iDecOpcode  = op;
    iDecRs1     = rs1;
    iDecRs2     = rs2;
    iDecRd      = rd;
    iIssueReady = ready;
    iWbValid    = wb_v;
    iWbRd       = wb_rd;
    iBrResolve  = br_res;
    iBrTaken    = br_tk;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    iRst = 1'b0;
    expectResetState();
    applyStimulus(0, eNOOP, 0, 0, 0, 1);

    $display("[TB] test 1: single immediate issue");
    expectStatus(K_IV, 1); expectStatus(K_DR, 0); expectStatus(K_CNT, 0);
    applyStimulus(1, eImmedi, 1, 0, 3, 0);
    expectIssue(eImmedi, 3); expectStatus(K_DR, 1);
    applyStimulus(1, eImmedi, 1, 0, 3, 1);
    expectStatus(K_CNT, 1); expectStatus(K_IV, 0);
    applyStimulus(0, eNOOP, 0, 0, 0, 1);

    $display("[TB] test 2: load-use RAW hazard");
    expectIssue(eLoad, 5); expectStatus(K_CNT, 1);
    applyStimulus(1, eLoad, 1, 0, 5, 1, 1, 3);
    expectStatus(K_CNT, 1); expectStatus(K_IV, 0);
    applyStimulus(1, eRtype, 5, 2, 6, 1);
    expectStatus(K_CNT, 1); expectStatus(K_IV, 0);
    applyStimulus(1, eRtype, 5, 2, 6, 1, 1, 5);
    expectStatus(K_CNT, 0); expectIssue(eRtype, 6);
    applyStimulus(1, eRtype, 5, 2, 6, 1);
    expectStatus(K_CNT, 1);
    applyStimulus(0, eNOOP, 0, 0, 0, 1, 1, 6);

    $display("[TB] test 3: x0 never pending");
    expectStatus(K_CNT, 0); expectIssue(eImmedi, 0);
    applyStimulus(1, eImmedi, 0, 0, 0, 1);
    expectStatus(K_CNT, 0); expectIssue(eRtype, 0);
    applyStimulus(1, eRtype, 0, 0, 0, 1);

    $display("[TB] test 4: taken branch and flush");
    expectStatus(K_CNT, 0); expectStatus(K_ERR, 0); expectIssue(eBranch, 7);
    applyStimulus(1, eBranch, 1, 2, 7, 1);
    expectStatus(K_IV, 0); expectStatus(K_CNT, 0);
    applyStimulus(1, eImmedi, 1, 0, 8, 1);
    expectStatus(K_IV, 0); expectStatus(K_FLUSH, 0);
    applyStimulus(1, eImmedi, 1, 0, 8, 1, 0, 0, 1, 1);
    expectStatus(K_FLUSH, 1); expectStatus(K_CNT, 0);
    applyStimulus(0, eNOOP, 0, 0, 0, 1);
    expectStatus(K_FLUSH, 0); expectIssue(eImmedi, 8);
    applyStimulus(1, eImmedi, 1, 0, 8, 1);
    expectStatus(K_CNT, 1);
    applyStimulus(0, eNOOP, 0, 0, 0, 1, 1, 8, 1, 1);

    $display("[TB] test 5: fence drains the pipe");
    expectStatus(K_FLUSH, 0); expectStatus(K_CNT, 0); expectIssue(eLoad, 10);
    applyStimulus(1, eLoad, 1, 0, 10, 1);
    expectStatus(K_CNT, 1); expectIssue(eLoad, 11);
    applyStimulus(1, eLoad, 1, 0, 11, 1);
    expectStatus(K_CNT, 2); expectStatus(K_IV, 0);
    applyStimulus(1, eFence, 0, 0, 0, 1);
    expectStatus(K_IV, 0);
    applyStimulus(1, eFence, 0, 0, 0, 1, 1, 10);
    expectStatus(K_CNT, 1); expectStatus(K_IV, 0);
    applyStimulus(1, eFence, 0, 0, 0, 1, 1, 11);
    expectStatus(K_CNT, 0); expectStatus(K_IV, 0);
    applyStimulus(1, eFence, 0, 0, 0, 1);
    expectIssue(eFence, 0);
    applyStimulus(1, eFence, 0, 0, 0, 1);

    $display("[TB] test 6: full window, WAW and writeback error");
    for (int r = 1; r <= 4; r++) begin
      expectStatus(K_CNT, r - 1); expectIssue(eImmedi, 5'(r));
      applyStimulus(1, eImmedi, 0, 0, 5'(r), 1);
    end
    expectStatus(K_CNT, 4); expectStatus(K_IV, 0);
    applyStimulus(1, eImmedi, 0, 0, 12, 1);
    expectStatus(K_IV, 0);
    applyStimulus(1, eImmedi, 0, 0, 12, 1, 1, 1);
    expectStatus(K_CNT, 3); expectIssue(eImmedi, 12);
    applyStimulus(1, eImmedi, 0, 0, 12, 1);
    expectStatus(K_CNT, 4); expectStatus(K_ERR, 0);
    applyStimulus(0, eNOOP, 0, 0, 0, 1, 1, 9);
    expectStatus(K_ERR, 1); expectStatus(K_CNT, 4);
    applyStimulus(0, eNOOP, 0, 0, 0, 1, 1, 2);
    expectStatus(K_CNT, 3); expectStatus(K_IV, 0);
    applyStimulus(1, eImmedi, 0, 0, 3, 1);
    expectStatus(K_IV, 0); expectStatus(K_ERR, 1);
    applyStimulus(1, eImmedi, 0, 0, 3, 1, 1, 3);
    expectStatus(K_CNT, 2); expectIssue(eImmedi, 3);
    applyStimulus(1, eImmedi, 0, 0, 3, 1);
    expectStatus(K_CNT, 3); expectStatus(K_ERR, 1);
    applyStimulus(0, eNOOP, 0, 0, 0, 1);

    $display("[TB] test 7: reset mid-operation");
    iRst = 1'b1;
    applyStimulus(0, eNOOP, 0, 0, 0, 1);
    iRst = 1'b0;
    expectResetState();
    applyStimulus(0, eNOOP, 0, 0, 0, 1);

    done = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
